// File: rtl/pipeline_irq_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_irq_ctrl
//
// Interrupt sequencer for the 5-stage pipeline. Two asynchronous external lines
// are synchronised, rising edges are latched as pending requests, and the
// highest-priority enabled request is taken when a real instruction commits in
// the M stage. Taking an interrupt flushes IF/ID/EX and redirects fetch to the
// line's vector, saving the return PC. An mret reaching M while in the handler
// flushes again and redirects fetch back to the saved PC.
//
// All state changes on the falling clock edge to line up with the pipeline
// registers. The reset is asynchronous and active-low.
//
// Ports
//   i_clock        pipeline clock (state updates on negedge)
//   i_clr_n        asynchronous active-low reset
//   i_irq_pins     [1:0] external interrupt lines, asynchronous, rising-edge
//   i_irq_mask     [1:0] per-line enable (1 = enabled)
//   i_gie          global interrupt enable
//   i_m_valid      M stage holds a real instruction
//   i_m_pc         [31:0] PC of the M-stage instruction
//   i_m_pcsrc      M-stage branch/jump taken
//   i_m_nextpc     [31:0] M-stage branch/jump target
//   i_m_mret       M-stage instruction is mret
//   o_flush        squash IF/ID, ID/EX and EX/M at this edge
//   o_redirect     override the IF next PC with o_redirect_pc
//   o_redirect_pc  [31:0] forced fetch address (0 when not redirecting)
//   o_irq_ack      [1:0] one-hot single-cycle acknowledge of the taken line
//   o_in_handler   handler active
//   o_cause        [1:0] one-hot line being serviced, held while in handler
//   o_epc          [31:0] saved return PC
// -----------------------------------------------------------------------------
module pipeline_irq_ctrl #(
    parameter logic [31:0] VEC0 = 32'h0000_0100,
    parameter logic [31:0] VEC1 = 32'h0000_0180
) (
    input  logic        i_clock,
    input  logic        i_clr_n,
    input  logic [1:0]  i_irq_pins,
    input  logic [1:0]  i_irq_mask,
    input  logic        i_gie,
    input  logic        i_m_valid,
    input  logic [31:0] i_m_pc,
    input  logic        i_m_pcsrc,
    input  logic [31:0] i_m_nextpc,
    input  logic        i_m_mret,
    output logic        o_flush,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic [1:0]  o_irq_ack,
    output logic        o_in_handler,
    output logic [1:0]  o_cause,
    output logic [31:0] o_epc
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_HANDLER = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  r_sync3;
    logic [1:0]  w_edge;

    logic [1:0]  r_pend;
    logic [1:0]  w_pend_next;
    logic [1:0]  w_req;
    logic [1:0]  w_sel;
    logic [31:0] w_sel_vec;
    logic        w_take;

    logic [31:0] r_epc;
    logic [31:0] w_epc_next;
    logic [1:0]  r_cause;
    logic [1:0]  w_cause_next;

    // Per-line two-flop synchroniser plus one delay flop for edge detection.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(negedge i_clock or negedge i_clr_n) begin
                if (!i_clr_n) begin
                    r_sync1[gi] <= 1'b0;
                    r_sync2[gi] <= 1'b0;
                    r_sync3[gi] <= 1'b0;
                end else begin
                    r_sync1[gi] <= i_irq_pins[gi];
                    r_sync2[gi] <= r_sync1[gi];
                    r_sync3[gi] <= r_sync2[gi];
                end
            end

            assign w_edge[gi] = r_sync2[gi] & ~r_sync3[gi];
        end
    endgenerate

    // A new edge in the same cycle as the acknowledge keeps the line pending,
    // so a request arriving while the previous one is being taken is not lost.
    assign w_pend_next = (r_pend & ~o_irq_ack) | w_edge;

    assign w_req     = r_pend & i_irq_mask;
    assign w_sel     = w_req[0] ? 2'b01 : (w_req[1] ? 2'b10 : 2'b00);
    assign w_sel_vec = w_req[0] ? VEC0 : VEC1;

    // The committing instruction must be real and must not itself be an mret,
    // otherwise the return address would be meaningless.
    assign w_take = i_gie & (|w_req) & i_m_valid & ~i_m_mret;

    always_comb begin
        w_state_next  = r_state;
        w_epc_next    = r_epc;
        w_cause_next  = r_cause;
        o_flush       = 1'b0;
        o_redirect    = 1'b0;
        o_redirect_pc = 32'h0;
        o_irq_ack     = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    o_flush       = 1'b1;
                    o_redirect    = 1'b1;
                    o_redirect_pc = w_sel_vec;
                    o_irq_ack     = w_sel;
                    // The M instruction retires, so return to its successor.
                    w_epc_next    = i_m_pcsrc ? i_m_nextpc : (i_m_pc + 32'd4);
                    w_cause_next  = w_sel;
                    w_state_next  = S_HANDLER;
                end
            end
            S_HANDLER: begin
                if (i_m_valid && i_m_mret) begin
                    o_flush       = 1'b1;
                    o_redirect    = 1'b1;
                    o_redirect_pc = r_epc;
                    w_cause_next  = 2'b00;
                    w_state_next  = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(negedge i_clock or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state <= S_IDLE;
            r_pend  <= 2'b00;
            r_epc   <= 32'h0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            r_epc   <= w_epc_next;
            r_cause <= w_cause_next;
        end
    end

    assign o_in_handler = (r_state == S_HANDLER);
    assign o_cause      = r_cause;
    assign o_epc        = r_epc;

endmodule

// File: tb/tb_pipeline_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_irq_ctrl
//
// Directed bench for the interrupt sequencer. Each cycle the stimulus code sets
// the inputs just after the falling edge and pushes the outputs it expects for
// that cycle onto a scoreboard queue; the entry is popped and compared on the
// following rising edge, half a cycle away from any state update.
// -----------------------------------------------------------------------------
module tb_pipeline_irq_ctrl;

    logic        clock;
    logic        clr_n;
    logic [1:0]  irq_pins;
    logic [1:0]  irq_mask;
    logic        gie;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_pcsrc;
    logic [31:0] m_nextpc;
    logic        m_mret;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  irq_ack;
    logic        in_handler;
    logic [1:0]  cause;
    logic [31:0] epc;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic        flush;
        logic        redirect;
        logic [31:0] rpc;
        logic [1:0]  ack;
        logic        inh;
        logic [1:0]  cause;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];

    pipeline_irq_ctrl dut (
        .i_clock       (clock),
        .i_clr_n       (clr_n),
        .i_irq_pins    (irq_pins),
        .i_irq_mask    (irq_mask),
        .i_gie         (gie),
        .i_m_valid     (m_valid),
        .i_m_pc        (m_pc),
        .i_m_pcsrc     (m_pcsrc),
        .i_m_nextpc    (m_nextpc),
        .i_m_mret      (m_mret),
        .o_flush       (flush),
        .o_redirect    (redirect),
        .o_redirect_pc (redirect_pc),
        .o_irq_ack     (irq_ack),
        .o_in_handler  (in_handler),
        .o_cause       (cause),
        .o_epc         (epc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Called at negedge+1 with this cycle's inputs already set.
    task automatic tick(input string tag, input logic f, input logic r,
                        input logic [31:0] rpc, input logic [1:0] ack,
                        input logic inh, input logic [1:0] cs, input logic [31:0] ep);
        exp_t e;
        exp_t got;
        e.tag = tag; e.flush = f; e.redirect = r; e.rpc = rpc;
        e.ack = ack; e.inh = inh; e.cause = cs; e.epc = ep;
        sb.push_back(e);
        @(posedge clock);
        got = sb.pop_front();
        check_val({got.tag, ".flush"},       {31'h0, flush},      {31'h0, got.flush});
        check_val({got.tag, ".redirect"},    {31'h0, redirect},   {31'h0, got.redirect});
        check_val({got.tag, ".redirect_pc"}, redirect_pc,         got.rpc);
        check_val({got.tag, ".irq_ack"},     {30'h0, irq_ack},    {30'h0, got.ack});
        check_val({got.tag, ".in_handler"},  {31'h0, in_handler}, {31'h0, got.inh});
        check_val({got.tag, ".cause"},       {30'h0, cause},      {30'h0, got.cause});
        check_val({got.tag, ".epc"},         epc,                 got.epc);
        $display("cycle %s: flush=%0b redir=%0b rpc=%h ack=%b inh=%0b cause=%b epc=%h",
                 got.tag, flush, redirect, redirect_pc, irq_ack, in_handler, cause, epc);
        @(negedge clock);
        #1;
    endtask

    task automatic quiet(input string tag, input logic inh, input logic [1:0] cs, input logic [31:0] ep);
        tick(tag, 1'b0, 1'b0, 32'h0, 2'b00, inh, cs, ep);
    endtask

    // One-cycle pin pulse followed by the synchroniser latency; the request is
    // pending and takeable in the cycle after this returns.
    task automatic pulse(input string tag, input logic [1:0] p, input logic inh,
                         input logic [1:0] cs, input logic [31:0] ep);
        irq_pins = p;
        quiet({tag, ".p0"}, inh, cs, ep);
        irq_pins = 2'b00;
        quiet({tag, ".p1"}, inh, cs, ep);
        quiet({tag, ".p2"}, inh, cs, ep);
    endtask

    task automatic take(input string tag, input logic [31:0] vec, input logic [1:0] ack,
                        input logic [31:0] pc, input logic pcsrc, input logic [31:0] npc,
                        input logic [31:0] old_epc, input logic [31:0] new_epc);
        m_valid = 1'b1; m_mret = 1'b0; m_pc = pc; m_pcsrc = pcsrc; m_nextpc = npc;
        tick({tag, ".take"}, 1'b1, 1'b1, vec, ack, 1'b0, 2'b00, old_epc);
        m_valid = 1'b0; m_pcsrc = 1'b0;
        quiet({tag, ".bubble"}, 1'b1, ack, new_epc);
    endtask

    task automatic ret(input string tag, input logic [1:0] cs, input logic [31:0] ep);
        m_valid = 1'b1; m_mret = 1'b1; m_pc = 32'h0000_0f00;
        tick({tag, ".mret"}, 1'b1, 1'b1, ep, 2'b00, 1'b1, cs, ep);
        m_valid = 1'b0; m_mret = 1'b0;
        quiet({tag, ".back"}, 1'b0, 2'b00, ep);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, ".flush"},       {31'h0, flush},      32'h0);
        check_val({tag, ".redirect"},    {31'h0, redirect},   32'h0);
        check_val({tag, ".redirect_pc"}, redirect_pc,         32'h0);
        check_val({tag, ".irq_ack"},     {30'h0, irq_ack},    32'h0);
        check_val({tag, ".in_handler"},  {31'h0, in_handler}, 32'h0);
        check_val({tag, ".cause"},       {30'h0, cause},      32'h0);
        check_val({tag, ".epc"},         epc,                 32'h0);
    endtask

    initial begin
        clr_n = 1'b0; irq_pins = 2'b00; irq_mask = 2'b11; gie = 1'b1;
        m_valid = 1'b0; m_pc = 32'h0; m_pcsrc = 1'b0; m_nextpc = 32'h0; m_mret = 1'b0;
        #2;
        check_outputs_zero("reset");
        @(negedge clock);
        #3 clr_n = 1'b1;
        @(negedge clock);
        #1;

        // Single irq on line 1, M holds a real instruction the whole time so the
        // take must land exactly three cycles after the pin rises.
        m_valid = 1'b1; m_pc = 32'h40;
        pulse("t1", 2'b10, 1'b0, 2'b00, 32'h0);
        take("t1", 32'h180, 2'b10, 32'h40, 1'b0, 32'h0, 32'h0, 32'h44);
        ret("t1", 2'b10, 32'h44);

        // Taken branch at the commit point: return to the branch target.
        m_valid = 1'b1; m_pc = 32'h80;
        pulse("t2", 2'b10, 1'b0, 2'b00, 32'h44);
        take("t2", 32'h180, 2'b10, 32'h80, 1'b1, 32'h200, 32'h44, 32'h200);
        ret("t2", 2'b10, 32'h200);

        // Both lines at once: line 0 first, line 1 waits out the handler.
        m_valid = 1'b1; m_pc = 32'h1000;
        pulse("t3", 2'b11, 1'b0, 2'b00, 32'h200);
        take("t3a", 32'h100, 2'b01, 32'h1000, 1'b0, 32'h0, 32'h200, 32'h1004);
        m_valid = 1'b1; m_pc = 32'h104;
        for (int i = 0; i < 3; i++) quiet("t3.nonest", 1'b1, 2'b01, 32'h1004);
        check_val("t3.pend", {30'h0, dut.r_pend}, 32'h2);
        ret("t3a", 2'b01, 32'h1004);
        take("t3b", 32'h180, 2'b10, 32'h1004, 1'b0, 32'h0, 32'h1004, 32'h1008);
        ret("t3b", 2'b10, 32'h1008);

        // Masked line stays pending, taken once unmasked.
        irq_mask = 2'b01; m_valid = 1'b1; m_pc = 32'h300;
        pulse("t4", 2'b10, 1'b0, 2'b00, 32'h1008);
        quiet("t4.masked", 1'b0, 2'b00, 32'h1008);
        quiet("t4.masked", 1'b0, 2'b00, 32'h1008);
        check_val("t4.pend", {30'h0, dut.r_pend}, 32'h2);
        irq_mask = 2'b11;
        take("t4", 32'h180, 2'b10, 32'h300, 1'b0, 32'h0, 32'h1008, 32'h304);
        ret("t4", 2'b10, 32'h304);

        // Bubble, gie and mret-in-idle gating; then PC wrap on the take.
        m_valid = 1'b0;
        pulse("t5", 2'b01, 1'b0, 2'b00, 32'h304);
        quiet("t5.bubble", 1'b0, 2'b00, 32'h304);
        gie = 1'b0; m_valid = 1'b1; m_pc = 32'hFFFF_FFFC;
        quiet("t5.nogie", 1'b0, 2'b00, 32'h304);
        quiet("t5.nogie", 1'b0, 2'b00, 32'h304);
        gie = 1'b1; m_mret = 1'b1;
        quiet("t5.idlemret", 1'b0, 2'b00, 32'h304);
        take("t5", 32'h100, 2'b01, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h304, 32'h0);
        ret("t5", 2'b01, 32'h0);

        // A pin held high requests only once.
        m_valid = 1'b1; m_pc = 32'h500; irq_pins = 2'b10;
        for (int i = 0; i < 3; i++) quiet("t6.sync", 1'b0, 2'b00, 32'h0);
        take("t6", 32'h180, 2'b10, 32'h500, 1'b0, 32'h0, 32'h0, 32'h504);
        ret("t6", 2'b10, 32'h504);
        m_valid = 1'b1; m_pc = 32'h504;
        for (int i = 0; i < 4; i++) quiet("t6.held", 1'b0, 2'b00, 32'h504);
        irq_pins = 2'b00;
        quiet("t6.drop", 1'b0, 2'b00, 32'h504);

        // Asynchronous reset while in the handler with another request pending
        // and an mret about to flush.
        m_valid = 1'b1; m_pc = 32'h600;
        pulse("t7", 2'b10, 1'b0, 2'b00, 32'h504);
        take("t7", 32'h180, 2'b10, 32'h600, 1'b0, 32'h0, 32'h504, 32'h604);
        pulse("t7.inh", 2'b01, 1'b1, 2'b10, 32'h604);
        check_val("t7.pend", {30'h0, dut.r_pend}, 32'h1);
        m_valid = 1'b1; m_mret = 1'b1;
        #1;
        check_val("t7.preflush", {31'h0, flush}, 32'h1);
        #2 clr_n = 1'b0;
        #1;
        check_outputs_zero("t7.rst");
        @(negedge clock);
        #3 clr_n = 1'b1;
        @(negedge clock);
        #1;
        m_mret = 1'b0; m_valid = 1'b1; m_pc = 32'h700;
        for (int i = 0; i < 4; i++) quiet("t7.after", 1'b0, 2'b00, 32'h0);
        pulse("t7.new", 2'b01, 1'b0, 2'b00, 32'h0);
        take("t7.new", 32'h100, 2'b01, 32'h700, 1'b0, 32'h0, 32'h0, 32'h704);
        ret("t7.new", 2'b01, 32'h704);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
